// File: rtl/uart_rx.sv
// UART receive deserializer: 8N1/8E1/8N2/8E2 frames on an OVERSAMPLE x baud clock.
// Optional UART_RX_MAJORITY_VOTE_EN: bit decisions use a 2-of-3 vote around mid-bit.
//
// state        | meaning
// S_IDLE       | line idle, waiting for a falling edge on rx_s
// S_START      | start bit, mid-sample confirms or rejects it
// S_DATA       | data bits 0..7, LSB first
// S_PARITY     | even parity bit
// S_STOP       | first stop bit
// S_EXTRA_STOP | second stop bit
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       arst_ni,
  input  logic       clk_i,
  input  logic       rx_i,
  input  logic       parity_en_i,
  input  logic       extra_stop_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       data_ready_i,
  output logic       parity_error_o,
  output logic       frame_error_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_EXTRA_STOP
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          perr, perr_nxt;
  logic          ferr, ferr_nxt;
  logic          par_cfg, stop2_cfg;
  logic          start_det, mid, bit_val, complete;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign start_det = (state == S_IDLE) && !rx_s && rx_d;
  assign mid       = (state != S_IDLE) && (cnt == MID);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // rx_d is the sample one cycle earlier, rx_meta the one a cycle later.
  assign bit_val = (rx_d & rx_s) | (rx_d & rx_meta) | (rx_s & rx_meta);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt <= '0;
    end else if (start_det || state == S_IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      par_cfg   <= 1'b0;
      stop2_cfg <= 1'b0;
    end else if (start_det) begin
      par_cfg   <= parity_en_i;
      stop2_cfg <= extra_stop_i;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shift_nxt = shift;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    complete  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_det) begin
          state_nxt = S_START;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (mid) begin
          state_nxt = bit_val ? S_IDLE : S_DATA;
          idx_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_nxt = {bit_val, shift[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = par_cfg ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid) begin
          perr_nxt  = bit_val ^ (^shift);
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          ferr_nxt = ferr | !bit_val;
          if (stop2_cfg) begin
            state_nxt = S_EXTRA_STOP;
          end else begin
            state_nxt = S_IDLE;
            complete  = 1'b1;
          end
        end
      end
      S_EXTRA_STOP: begin
        if (mid) begin
          ferr_nxt  = ferr | !bit_val;
          state_nxt = S_IDLE;
          complete  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state <= S_IDLE;
      idx   <= 3'd0;
      shift <= 8'h00;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      perr  <= perr_nxt;
      ferr  <= ferr_nxt;
    end
  end

  // A completed frame lands only if the holding register is free or being emptied.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      data_o         <= 8'h00;
      data_valid_o   <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (data_valid_o && data_ready_i) data_valid_o <= 1'b0;
      if (complete) begin
        if (!data_valid_o || data_ready_i) begin
          data_o         <= shift;
          parity_error_o <= perr_nxt;
          frame_error_o  <= ferr_nxt;
          data_valid_o   <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

  assign busy_o = (state != S_IDLE);

endmodule
